fvc_gate_gen: RTL and testbench
===============================

Name: fvc_gate_gen

Overview:
- Parametrised gate/timebase generator for the frequency-measurement path.
- Produces a counter-clear pulse, a programmable-length count gate and a latch strobe, in single-shot or continuous mode.
- Sits between the system clock and the measured-signal counter/latch pair.
- Adds over the previous fixed-period generator: run-time gate length, start/abort control, busy/done status and a measurement counter.

Parameters:
- CNT_W, 20, width of gate-length input and internal cycle counter.
- CLR_CYC, 1, number of cycles en_clear is held high (must be >= 1).
- SETTLE_CYC, 2, idle cycles between gate close and latch strobe, for counter pipeline settling (must be >= 0).
- MEAS_W, 16, width of the completed-measurement counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- CR  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin a measurement; sampled only in IDLE.
- cont  in  1  1 = continuous mode (auto-restart), 0 = single-shot.
- abort  in  1  terminates the current measurement without latching.
- gate_len  in  CNT_W  gate length in clk cycles; 0 is treated as 1.
- en_clear  out  1  high while the external counter must be cleared.
- en_count  out  1  high while the external counter may count (gate open).
- en_latch  out  1  one-cycle strobe to capture the counter value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, coincident with en_latch.
- meas_cnt  out  MEAS_W  number of completed latches since reset; wraps.

Behaviour:
- Clocking/reset: one clock, clk. CR is synchronous and active-high. While CR=1 at a rising edge: state=IDLE; internal counter=0; meas_cnt=0; en_clear=en_count=en_latch=busy=done=0.
- Outputs: all are registered Moore outputs decoded from the registered state. There is no combinational path from any input to any output.
- States: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE: all strobes 0, busy=0. Go to CLEAR if start=1 or cont=1.
- Gate-length capture: on leaving IDLE, and on each continuous restart out of LATCH, capture gate_r = (gate_len==0) ? 1 : gate_len. gate_len changes mid-measurement have no effect.
- CLEAR: en_clear=1 for exactly CLR_CYC cycles, then GATE.
- GATE: en_count=1 for exactly gate_r cycles, then SETTLE. If SETTLE_CYC=0, go straight to LATCH.
- SETTLE: all strobes 0 for SETTLE_CYC cycles, then LATCH.
- LATCH: one cycle with en_latch=1 and done=1; meas_cnt increments by 1 (modulo 2^MEAS_W). Next state is CLEAR if cont=1, otherwise IDLE.
- Latency and period:
  - start high at edge N puts en_clear high from cycle N+1.
  - Period = CLR_CYC + gate_r + SETTLE_CYC + 1 cycles.
  - In continuous mode consecutive periods are back-to-back, with no IDLE cycle between them.
- Internal counter: a down-counter of CNT_W bits, reloaded on each state entry. It must not overflow for gate_len = 2^CNT_W - 1.
- Abort:
  - abort=1 in CLEAR, GATE or SETTLE: IDLE on the next edge, no en_latch, no done, meas_cnt unchanged.
  - abort in LATCH: the latch completes, then go to IDLE regardless of cont.
  - abort in IDLE: ignored, and it overrides start/cont that cycle.
- Priority: CR > abort > start/cont.
- start outside IDLE: ignored.
- cont deasserted mid-measurement: the current measurement completes, then IDLE.
- en_clear, en_count and en_latch are mutually exclusive at all times; at most one is high in any cycle.

Test Plan:
- CR=1 for 3 cycles with start=1 -> all outputs 0, meas_cnt=0. After CR release, one start pulse, gate_len=10, defaults -> en_clear 1 cycle, en_count 10 cycles, 2 idle cycles, en_latch/done 1 cycle, meas_cnt=1, busy high 14 cycles.
- cont=1, gate_len=5 for 3 periods -> periods of 9 cycles, back-to-back; en_latch at cycles 9, 18, 27 after the first CLEAR cycle; meas_cnt=3. Drop cont during the 3rd GATE -> IDLE after that latch.
- gate_len=0 -> en_count exactly 1 cycle. gate_len=2^CNT_W-1 with CNT_W=8 -> en_count exactly 255 cycles.
- abort asserted at the 4th GATE cycle -> IDLE next edge, no en_latch, meas_cnt unchanged. abort during LATCH with cont=1 -> latch completes, then IDLE.
- Change gate_len from 10 to 3 mid-GATE, with cont=1 -> current gate is 10 cycles, next gate is 3 cycles. start pulses while busy -> no effect.
- MEAS_W=2, run 5 measurements -> meas_cnt sequence 1, 2, 3, 0, 1. SETTLE_CYC=0 -> en_latch in the cycle immediately after the last en_count cycle.

Source files
------------

// File: rtl/fvc_gate_gen.sv
// Gate/timebase generator for the frequency-measurement path: clear pulse,
// run-time-programmable count gate and latch strobe, single-shot or continuous.
module fvc_gate_gen #(
   parameter int CNT_W      = 20,
   parameter int CLR_CYC    = 1,
   parameter int SETTLE_CYC = 2,
   parameter int MEAS_W     = 16
) (
   input  logic              clk,
   input  logic              CR,
   input  logic              start,
   input  logic              cont,
   input  logic              abort,
   input  logic [CNT_W-1:0]  gate_len,
   output logic              en_clear,
   output logic              en_count,
   output logic              en_latch,
   output logic              busy,
   output logic              done,
   output logic [MEAS_W-1:0] meas_cnt
);

   typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH} state_t;

   // Down-counter reload values hold "cycles - 1" so a full-scale gate fits in CNT_W bits
   localparam logic [CNT_W-1:0] CLR_LOAD    = CNT_W'(CLR_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   gate_q, gate_d;
   logic [MEAS_W-1:0]  meas_q, meas_d;
   logic [CNT_W-1:0]   gateLoad;
   logic               cntZero;

   assign gateLoad = (gate_len == '0) ? '0 : gate_len - CNT_W'(1);
   assign cntZero  = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gate_d  = gate_q;
      meas_d  = meas_q;
      unique case (state_q)
         IDLE: begin
            if (!abort && (start || cont)) begin
               state_d = CLEAR;
               cnt_d   = CLR_LOAD;
               gate_d  = gateLoad;
            end
         end
         CLEAR: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cntZero) begin
               state_d = GATE;
               cnt_d   = gate_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GATE: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cntZero) begin
               if (SETTLE_CYC == 0) begin
                  state_d = LATCH;
                  meas_d  = meas_q + MEAS_W'(1);
               end else begin
                  state_d = SETTLE;
                  cnt_d   = SETTLE_LOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cntZero) begin
               state_d = LATCH;
               meas_d  = meas_q + MEAS_W'(1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         LATCH: begin
            if (cont && !abort) begin
               state_d = CLEAR;
               cnt_d   = CLR_LOAD;
               gate_d  = gateLoad;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Strobes are decoded from the next state so they line up with the registered state
   always_ff @(posedge clk) begin
      if (CR) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         gate_q   <= '0;
         meas_q   <= '0;
         en_clear <= 1'b0;
         en_count <= 1'b0;
         en_latch <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gate_q   <= gate_d;
         meas_q   <= meas_d;
         en_clear <= (state_d == CLEAR);
         en_count <= (state_d == GATE);
         en_latch <= (state_d == LATCH);
         busy     <= (state_d != IDLE);
         done     <= (state_d == LATCH);
      end
   end

   assign meas_cnt = meas_q;

endmodule

// File: tb/tb_fvc_gate_gen.sv
// Scoreboard bench for fvc_gate_gen: expected per-cycle strobe vectors are queued
// as stimulus is driven and compared cycle by cycle against two parameterisations.
module tb_fvc_gate_gen;

   localparam int CLR_A = 1;
   localparam int SET_A = 2;
   localparam int CLR_B = 2;
   localparam int SET_B = 0;

   logic        clk = 1'b0;
   logic        CR;
   logic        startA, contA, abortA;
   logic [19:0] glA;
   logic        clrA, cntA, latA, busyA, doneA;
   logic [15:0] measA;
   logic        startB, contB, abortB;
   logic [7:0]  glB;
   logic        clrB, cntB, latB, busyB, doneB;
   logic [1:0]  measB;

   logic [4:0]  obsA, obsB;
   logic [4:0]  qA[$];
   logic [4:0]  qB[$];
   int          expMeasA = 0;
   int          expMeasB = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   assign obsA = {clrA, cntA, latA, busyA, doneA};
   assign obsB = {clrB, cntB, latB, busyB, doneB};

   fvc_gate_gen dutA (
      .clk(clk), .CR(CR), .start(startA), .cont(contA), .abort(abortA), .gate_len(glA),
      .en_clear(clrA), .en_count(cntA), .en_latch(latA), .busy(busyA), .done(doneA),
      .meas_cnt(measA)
   );

   fvc_gate_gen #(.CNT_W(8), .CLR_CYC(CLR_B), .SETTLE_CYC(SET_B), .MEAS_W(2)) dutB (
      .clk(clk), .CR(CR), .start(startB), .cont(contB), .abort(abortB), .gate_len(glB),
      .en_clear(clrB), .en_count(cntB), .en_latch(latB), .busy(busyB), .done(doneB),
      .meas_cnt(measB)
   );

   // Vector layout: {en_clear, en_count, en_latch, busy, done}
   function automatic void pushVec(input bit selB, input logic [4:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         if (selB) qB.push_back(v);
         else      qA.push_back(v);
      end
   endfunction

   function automatic void pushFrame(input bit selB, input int clr, input int g, input int s);
      pushVec(selB, 5'b10010, clr);
      pushVec(selB, 5'b01010, g);
      pushVec(selB, 5'b00010, s);
      pushVec(selB, 5'b00111, 1);
      if (selB) expMeasB++;
      else      expMeasA++;
   endfunction

   task automatic test_reset;
      CR = 1'b1; startA = 1'b1; startB = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (obsA !== 5'b0 || obsB !== 5'b0 || measA !== 16'd0 || measB !== 2'd0) begin
            bad++;
            $display("[TB] FAIL reset cyc=%0d got A=%b B=%b measA=%0d measB=%0d want all 0",
                     i, obsA, obsB, measA, measB);
         end
      end
      CR = 1'b0; startA = 1'b0; startB = 1'b0;
      @(negedge clk);
      total++;
      if (obsA !== 5'b0 || obsB !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_idle got A=%b B=%b want 00000", obsA, obsB);
      end
   endtask

   task automatic test_single;
      int n;
      logic [4:0] want;
      glA = 20'd10; startA = 1'b1;
      pushFrame(0, CLR_A, 10, SET_A);
      pushVec(0, 5'b0, 2);
      n = qA.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         startA = 1'b0;
         want = qA.pop_front();
         total++;
         if (obsA !== want) begin
            bad++;
            $display("[TB] FAIL single cyc=%0d got=%b want=%b", i, obsA, want);
         end
      end
      total++;
      if (measA !== 16'(expMeasA)) begin
         bad++;
         $display("[TB] FAIL single_meas got=%0d want=%0d", measA, expMeasA);
      end
   endtask

   task automatic test_continuous;
      int n;
      logic [4:0] want;
      glA = 20'd5; contA = 1'b1;
      pushFrame(0, CLR_A, 5, SET_A);
      pushFrame(0, CLR_A, 5, SET_A);
      pushFrame(0, CLR_A, 5, SET_A);
      pushVec(0, 5'b0, 2);
      n = qA.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         want = qA.pop_front();
         total++;
         if (obsA !== want) begin
            bad++;
            $display("[TB] FAIL continuous cyc=%0d got=%b want=%b", i, obsA, want);
         end
         if (i == 20) contA = 1'b0;
      end
      total++;
      if (measA !== 16'(expMeasA)) begin
         bad++;
         $display("[TB] FAIL continuous_meas got=%0d want=%0d", measA, expMeasA);
      end
   endtask

   task automatic test_gate_zero;
      int n;
      logic [4:0] want;
      glA = 20'd0; startA = 1'b1;
      pushFrame(0, CLR_A, 1, SET_A);
      pushVec(0, 5'b0, 1);
      n = qA.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         startA = 1'b0;
         want = qA.pop_front();
         total++;
         if (obsA !== want) begin
            bad++;
            $display("[TB] FAIL gate_zero cyc=%0d got=%b want=%b", i, obsA, want);
         end
      end
   endtask

   task automatic test_abort;
      int n;
      logic [4:0] want;
      glA = 20'd10; startA = 1'b1;
      pushVec(0, 5'b10010, CLR_A);
      pushVec(0, 5'b01010, 4);
      pushVec(0, 5'b0, 2);
      n = qA.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         startA = 1'b0;
         want = qA.pop_front();
         total++;
         if (obsA !== want) begin
            bad++;
            $display("[TB] FAIL abort_gate cyc=%0d got=%b want=%b", i, obsA, want);
         end
         if (i == 3 + CLR_A) abortA = 1'b1;
         if (i == 4 + CLR_A) abortA = 1'b0;
      end
      // abort in IDLE beats a simultaneous start
      startA = 1'b1; abortA = 1'b1;
      pushVec(0, 5'b0, 2);
      n = qA.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         startA = 1'b0; abortA = 1'b0;
         want = qA.pop_front();
         total++;
         if (obsA !== want) begin
            bad++;
            $display("[TB] FAIL abort_idle cyc=%0d got=%b want=%b", i, obsA, want);
         end
      end
      total++;
      if (measA !== 16'(expMeasA)) begin
         bad++;
         $display("[TB] FAIL abort_meas got=%0d want=%0d", measA, expMeasA);
      end
   endtask

   task automatic test_abort_latch;
      int n;
      logic [4:0] want;
      glA = 20'd3; contA = 1'b1;
      pushFrame(0, CLR_A, 3, SET_A);
      pushVec(0, 5'b0, 2);
      n = qA.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         want = qA.pop_front();
         total++;
         if (obsA !== want) begin
            bad++;
            $display("[TB] FAIL abort_latch cyc=%0d got=%b want=%b", i, obsA, want);
         end
         if (i == CLR_A + 3 + SET_A) abortA = 1'b1;
         if (i == CLR_A + 4 + SET_A) begin
            abortA = 1'b0;
            contA  = 1'b0;
         end
      end
      total++;
      if (measA !== 16'(expMeasA)) begin
         bad++;
         $display("[TB] FAIL abort_latch_meas got=%0d want=%0d", measA, expMeasA);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      logic [4:0] want;
      glA = 20'd10; contA = 1'b1;
      pushFrame(0, CLR_A, 10, SET_A);
      pushFrame(0, CLR_A, 3, SET_A);
      pushVec(0, 5'b0, 2);
      n = qA.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         want = qA.pop_front();
         total++;
         if (obsA !== want) begin
            bad++;
            $display("[TB] FAIL back_to_back cyc=%0d got=%b want=%b", i, obsA, want);
         end
         if (i == 2)  startA = 1'b1;
         if (i == 3)  startA = 1'b0;
         if (i == 4)  glA    = 20'd3;
         if (i == 16) contA  = 1'b0;
         if (i == 18) startA = 1'b1;
         if (i == 19) startA = 1'b0;
      end
      total++;
      if (measA !== 16'(expMeasA)) begin
         bad++;
         $display("[TB] FAIL back_to_back_meas got=%0d want=%0d", measA, expMeasA);
      end
   endtask

   task automatic test_wrap;
      int n;
      logic [4:0] want;
      for (int k = 0; k < 5; k++) begin
         glB = 8'd1; startB = 1'b1;
         pushFrame(1, CLR_B, 1, SET_B);
         pushVec(1, 5'b0, 1);
         n = qB.size();
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            startB = 1'b0;
            want = qB.pop_front();
            total++;
            if (obsB !== want) begin
               bad++;
               $display("[TB] FAIL wrap run=%0d cyc=%0d got=%b want=%b", k, i, obsB, want);
            end
         end
         total++;
         if (measB !== 2'(expMeasB % 4)) begin
            bad++;
            $display("[TB] FAIL wrap_meas run=%0d got=%0d want=%0d", k, measB, expMeasB % 4);
         end
      end
   endtask

   task automatic test_gate_max;
      int n;
      int gateCyc;
      logic [4:0] want;
      glB = 8'd255; startB = 1'b1;
      gateCyc = 0;
      pushFrame(1, CLR_B, 255, SET_B);
      pushVec(1, 5'b0, 1);
      n = qB.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         startB = 1'b0;
         if (cntB === 1'b1) gateCyc++;
         want = qB.pop_front();
         total++;
         if (obsB !== want) begin
            bad++;
            $display("[TB] FAIL gate_max cyc=%0d got=%b want=%b", i, obsB, want);
         end
      end
      total++;
      if (gateCyc != 255) begin
         bad++;
         $display("[TB] FAIL gate_max_len got=%0d want=255", gateCyc);
      end
      total++;
      if (measB !== 2'(expMeasB % 4)) begin
         bad++;
         $display("[TB] FAIL gate_max_meas got=%0d want=%0d", measB, expMeasB % 4);
      end
   endtask

   initial begin
      CR = 1'b1;
      startA = 1'b0; contA = 1'b0; abortA = 1'b0; glA = '0;
      startB = 1'b0; contB = 1'b0; abortB = 1'b0; glB = '0;
      test_reset();
      test_single();
      test_continuous();
      test_gate_zero();
      test_abort();
      test_abort_latch();
      test_back_to_back();
      test_wrap();
      test_gate_max();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
